// File: rtl/phase_seq.sv
// phase_seq: drives a step engine across a runtime block range with
// bounded per-block retry, draining abort and fail-location reporting.
`timescale 1ns/1ps
module phase_seq #(
    parameter int N = 4,
    parameter int L = 8,
    parameter int K = 16,
    parameter int MAX_RETRY = 1,
    localparam int NB = K / N,
    localparam int CB = $clog2(NB + 1),
    localparam int FW = $clog2(L * K / N + 2 * N + 1),
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          last_phase,
    input  logic [CB-1:0] start_block,
    input  logic [CB-1:0] end_block,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic          aborted,
    output logic          range_err,
    output logic [CB-1:0] fail_block,
    output logic [CB-1:0] steps_ok,
    output logic          step_start,
    output logic [CB-1:0] step_col_block,
    output logic [FW-1:0] step_first_pass_rows,
    output logic          step_functionA,
    output logic          step_last_phase,
    input  logic          step_done,
    input  logic          step_fail
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [CB-1:0] sb_q, sb_d;
    logic [CB-1:0] eb_q, eb_d;
    logic [CB-1:0] col_q, col_d;
    logic [CB-1:0] ok_q, ok_d;
    logic [CB-1:0] fblk_q, fblk_d;
    logic [FW-1:0] fpr_q, fpr_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          abort_q, abort_d;
    logic          fail_q, fail_d;
    logic          aborted_q, aborted_d;
    logic          rerr_q, rerr_d;
    logic          lp_q, lp_d;
    logic          abort_eff;

    // A request seen this cycle counts as much as an earlier one.
    assign abort_eff = abort_q | abort;

    assign busy                 = (state_q != IDLE);
    assign done                 = (state_q == FINISH);
    assign step_start           = (state_q == ISSUE) && !abort_eff;
    assign step_functionA       = (step_start || state_q == WAIT)
                                  && (col_q == sb_q);
    assign fail                 = fail_q;
    assign aborted              = aborted_q;
    assign range_err            = rerr_q;
    assign fail_block           = fblk_q;
    assign steps_ok             = ok_q;
    assign step_col_block       = col_q;
    assign step_first_pass_rows = fpr_q;
    assign step_last_phase      = lp_q;

    always_comb begin
        state_d   = state_q;
        sb_d      = sb_q;
        eb_d      = eb_q;
        col_d     = col_q;
        ok_d      = ok_q;
        fblk_d    = fblk_q;
        fpr_d     = fpr_q;
        retry_d   = retry_q;
        abort_d   = abort_q;
        fail_d    = fail_q;
        aborted_d = aborted_q;
        rerr_d    = rerr_q;
        lp_d      = lp_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CHECK;
                    lp_d      = last_phase;
                    sb_d      = start_block;
                    eb_d      = end_block;
                    col_d     = start_block;
                    fpr_d     = FW'(L) * FW'(start_block) + FW'(L)
                                - FW'(N) * FW'(start_block);
                    abort_d   = 1'b0;
                    retry_d   = '0;
                    ok_d      = '0;
                    fblk_d    = '0;
                    fail_d    = 1'b0;
                    aborted_d = 1'b0;
                    rerr_d    = 1'b0;
                end
            end
            CHECK: begin
                abort_d = abort_eff;
                if (sb_q > eb_q || eb_q >= CB'(NB)) begin
                    rerr_d  = 1'b1;
                    fail_d  = 1'b1;
                    state_d = FINISH;
                end else if (abort_eff) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                abort_d = abort_eff;
                if (abort_eff) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                abort_d = abort_eff;
                if (step_done && !step_fail) begin
                    ok_d    = ok_q + CB'(1);
                    retry_d = '0;
                    if (col_q == eb_q) begin
                        state_d = FINISH;
                    end else if (abort_eff) begin
                        aborted_d = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        col_d   = col_q + CB'(1);
                        state_d = ISSUE;
                    end
                end else if (step_done) begin
                    // Retry exhaustion wins over a pending abort.
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ISSUE;
                    end else begin
                        fail_d  = 1'b1;
                        fblk_d  = col_q;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sb_q      <= '0;
            eb_q      <= '0;
            col_q     <= '0;
            ok_q      <= '0;
            fblk_q    <= '0;
            fpr_q     <= '0;
            retry_q   <= '0;
            abort_q   <= 1'b0;
            fail_q    <= 1'b0;
            aborted_q <= 1'b0;
            rerr_q    <= 1'b0;
            lp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sb_q      <= sb_d;
            eb_q      <= eb_d;
            col_q     <= col_d;
            ok_q      <= ok_d;
            fblk_q    <= fblk_d;
            fpr_q     <= fpr_d;
            retry_q   <= retry_d;
            abort_q   <= abort_d;
            fail_q    <= fail_d;
            aborted_q <= aborted_d;
            rerr_q    <= rerr_d;
            lp_q      <= lp_d;
        end
    end

endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: directed runs of phase_seq against a behavioural step
// engine that answers 5 cycles after each step_start.
`timescale 1ns/1ps
module tb_phase_seq;

    localparam int CB = 3;
    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          last_phase;
    logic [CB-1:0] start_block;
    logic [CB-1:0] end_block;
    logic          abort;
    logic          busy;
    logic          done;
    logic          fail;
    logic          aborted;
    logic          range_err;
    logic [CB-1:0] fail_block;
    logic [CB-1:0] steps_ok;
    logic          step_start;
    logic [CB-1:0] step_col_block;
    logic [FW-1:0] step_first_pass_rows;
    logic          step_functionA;
    logic          step_last_phase;
    logic          step_done;
    logic          step_fail;

    always #5 clk = ~clk;

    phase_seq #(.N(4), .L(8), .K(16), .MAX_RETRY(1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .last_phase           (last_phase),
        .start_block          (start_block),
        .end_block            (end_block),
        .abort                (abort),
        .busy                 (busy),
        .done                 (done),
        .fail                 (fail),
        .aborted              (aborted),
        .range_err            (range_err),
        .fail_block           (fail_block),
        .steps_ok             (steps_ok),
        .step_start           (step_start),
        .step_col_block       (step_col_block),
        .step_first_pass_rows (step_first_pass_rows),
        .step_functionA       (step_functionA),
        .step_last_phase      (step_last_phase),
        .step_done            (step_done),
        .step_fail            (step_fail)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int n_fa = 0;
    int done_cyc = 0;
    int last_done_cyc = 0;
    int fail_done_cyc = 0;
    int first_start_cyc = 0;
    int eng_cnt = 0;
    int fail_blk = -1;
    int fail_left = 0;
    int t0 = 0;
    logic [CB-1:0] eng_col = '0;
    int col_log[8];
    int fa_log[8];
    int sc_log[8];

    // Step engine and monitor, sampling 2 time units after each edge.
    initial begin
        step_done = 1'b0;
        step_fail = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (step_functionA === 1'b1) n_fa++;
            step_done = 1'b0;
            step_fail = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    step_done = 1'b1;
                    last_done_cyc = cyc;
                    if (int'(eng_col) == fail_blk && fail_left > 0) begin
                        step_fail = 1'b1;
                        fail_left--;
                        fail_done_cyc = cyc;
                    end
                end
            end
            if (step_start === 1'b1) begin
                if (n_start < 8) begin
                    col_log[n_start] = int'(step_col_block);
                    fa_log[n_start]  = int'(step_functionA);
                    sc_log[n_start]  = cyc;
                end
                if (n_start == 0) first_start_cyc = cyc;
                n_start++;
                eng_col = step_col_block;
                eng_cnt = 5;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_cols(input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n && i < 8; i++) v = (v << 4) | 32'(col_log[i]);
        return v;
    endfunction

    function automatic logic [31:0] pack_fa(input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n && i < 8; i++) v = (v << 1) | 32'(fa_log[i]);
        return v;
    endfunction

    task automatic clear_logs();
        n_start = 0;
        n_done = 0;
        n_fa = 0;
        fail_blk = -1;
        fail_left = 0;
    endtask

    task automatic run_start(input int sb, input int eb, input logic lp);
        @(posedge clk);
        #1;
        start = 1'b1;
        start_block = CB'(sb);
        end_block = CB'(eb);
        last_phase = lp;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int prev;
        prev = n_done;
        for (int i = 0; i < limit && n_done == prev; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, n_done, prev + 1);
    endtask

    task automatic wait_starts(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && n_start < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, n_start, n);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        last_phase = 1'b0;
        start_block = '0;
        end_block = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {busy, done, step_start, step_functionA, step_last_phase}, 0);
        chk("rst_status", {fail, aborted, range_err}, 0);
        chk("rst_counters", {fail_block, steps_ok, step_col_block}, 0);
        chk("rst_rows", step_first_pass_rows, 0);
        rst = 1'b1;

        // Full range 0..3
        clear_logs();
        run_start(0, 3, 1'b1);
        chk("t1_busy", busy, 1);
        chk("t1_rows", step_first_pass_rows, 8);
        wait_done("t1_done", 200);
        chk("t1_busy_after", busy, 0);
        chk("t1_starts", n_start, 4);
        chk("t1_cols", pack_cols(4), 32'h0123);
        chk("t1_fa_at_start", pack_fa(4), 32'b1000);
        chk("t1_fa_cycles", n_fa, 6);
        chk("t1_lat_start", first_start_cyc - t0, 2);
        chk("t1_lat_done", done_cyc - last_done_cyc, 1);
        chk("t1_status", {fail, aborted, range_err}, 0);
        chk("t1_steps_ok", steps_ok, 4);
        chk("t1_last_phase", step_last_phase, 1);

        // Partial range 2..3
        clear_logs();
        run_start(2, 3, 1'b0);
        chk("t2_rows", step_first_pass_rows, 16);
        wait_done("t2_done", 200);
        chk("t2_starts", n_start, 2);
        chk("t2_cols", pack_cols(2), 32'h23);
        chk("t2_fa_at_start", pack_fa(2), 32'b10);
        chk("t2_steps_ok", steps_ok, 2);
        chk("t2_fail", fail, 0);
        chk("t2_last_phase", step_last_phase, 0);

        // One failure at block 1, retry succeeds
        clear_logs();
        fail_blk = 1;
        fail_left = 1;
        run_start(0, 3, 1'b0);
        wait_done("t3_done", 300);
        chk("t3_starts", n_start, 5);
        chk("t3_cols", pack_cols(5), 32'h01123);
        chk("t3_retry_gap", sc_log[2] - fail_done_cyc, 1);
        chk("t3_fa_at_start", pack_fa(5), 32'b10000);
        chk("t3_steps_ok", steps_ok, 4);
        chk("t3_fail", {fail, fail_block}, 0);

        // Two failures at block 1 exhaust the retry
        clear_logs();
        fail_blk = 1;
        fail_left = 2;
        run_start(0, 3, 1'b0);
        wait_done("t4_done", 300);
        chk("t4_starts", n_start, 3);
        chk("t4_cols", pack_cols(3), 32'h011);
        chk("t4_fail", fail, 1);
        chk("t4_fail_block", fail_block, 1);
        chk("t4_steps_ok", steps_ok, 1);
        chk("t4_flags", {aborted, range_err}, 0);

        // Abort during block 1 WAIT, with a start while busy
        clear_logs();
        run_start(0, 3, 1'b0);
        wait_starts("t5_reach_blk1", 2, 100);
        abort = 1'b1;
        start = 1'b1;
        start_block = 3'd3;
        end_block = 3'd3;
        last_phase = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t5_done", 100);
        abort = 1'b0;
        chk("t5_starts", n_start, 2);
        chk("t5_aborted", aborted, 1);
        chk("t5_fail", fail, 0);
        chk("t5_steps_ok", steps_ok, 2);
        chk("t5_lat_done", done_cyc - last_done_cyc, 1);
        chk("t5_last_phase", step_last_phase, 0);
        chk("t5_rows", step_first_pass_rows, 8);
        chk("t5_col", step_col_block, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_rerun", {n_done[7:0], n_start[7:0]}, {8'd1, 8'd2});

        // Range error 3..1
        clear_logs();
        run_start(3, 1, 1'b0);
        chk("t6_busy", busy, 1);
        wait_done("t6_done", 20);
        chk("t6_lat_done", done_cyc - t0, 2);
        chk("t6_flags", {range_err, fail, aborted}, 3'b110);
        chk("t6_starts", n_start, 0);
        chk("t6_steps_ok", steps_ok, 0);

        // Async reset in WAIT of block 1
        clear_logs();
        run_start(0, 3, 1'b1);
        wait_starts("t7_reach_blk1", 2, 100);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t7_ctl", {busy, done, step_start, step_functionA, step_last_phase}, 0);
        chk("t7_status", {fail, aborted, range_err}, 0);
        chk("t7_counters", {fail_block, steps_ok, step_col_block}, 0);
        chk("t7_rows", step_first_pass_rows, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("t7_no_done", n_done, 0);
        chk("t7_no_start", n_start, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_seq.md
# phase_seq

Parametrised successor to the step-sequencing phase controller. It drives an external step engine across a runtime-selected range of column blocks `[start_block, end_block]` instead of always running to the last block. It retries a failed step a bounded number of times, supports a draining abort, and reports progress and fail location. It sits between the top-level elimination controller and the step engine; memory ports stay on the step engine and do not pass through this block.

## Interface
Parameters:
- `N`, 4: rows/columns per block.
- `L`, 8: row count of the matrix slice.
- `K`, 16: total columns; `NB = K/N` blocks, with `K % N == 0` required.
- `MAX_RETRY`, 1: re-issues allowed per block after a step fail (0 disables retry).
- Derived widths: `CB = CLOG2(NB+1)`, `FW = CLOG2(L*K/N+2*N+1)`, `RW = CLOG2(MAX_RETRY+1)`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only when `busy==0`.
- `last_phase` in 1: sampled at start, held on `step_last_phase`.
- `start_block` in CB: first block, sampled at start.
- `end_block` in CB: last block, inclusive, sampled at start.
- `abort` in 1: level request to stop after the in-flight step.
- `busy` out 1: high from the cycle after start is accepted through the FINISH cycle.
- `done` out 1: one-cycle pulse in the FINISH state.
- `fail` out 1: valid with `done`, held until the next accepted start.
- `aborted` out 1: valid with `done`, held until the next accepted start.
- `range_err` out 1: valid with `done`, held until the next accepted start.
- `fail_block` out CB: block that exhausted its retries.
- `steps_ok` out CB: count of successfully completed steps this run.
- `step_start` out 1: one-cycle pulse to the step engine.
- `step_col_block` out CB: block under processing; stable from `step_start` until `step_done`.
- `step_first_pass_rows` out FW: `L*start_block + L - N*start_block`, latched at start.
- `step_functionA` out 1: high from the first `step_start` of the run until its `step_done`.
- `step_last_phase` out 1: latched copy of `last_phase`.
- `step_done` in 1: one-cycle completion pulse from the step engine.
- `step_fail` in 1: qualified by `step_done`.

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, FINISH.
- **IDLE, `start` asserted:** latch all inputs, clear the status outputs, `steps_ok`, `fail_block` and `retry_cnt`, then go to CHECK.
- **CHECK:**
  - If `start_block > end_block` or `end_block >= NB`: set `range_err` and `fail`, go to FINISH, and issue no step.
  - Otherwise go to ISSUE.
- **ISSUE:** pulse `step_start` and go to WAIT. `step_functionA` rises here only when this is the run's first issue. A retry of the first block re-asserts it.
- **WAIT, `step_done && !step_fail`:**
  - Increment `steps_ok` and clear `retry_cnt`.
  - If `step_col_block == end_block`, go to FINISH.
  - Else if the abort flag is set, set `aborted` and go to FINISH.
  - Else increment `step_col_block` and go to ISSUE.
- **WAIT, `step_done && step_fail`:**
  - If `retry_cnt < MAX_RETRY`: increment `retry_cnt` and go to ISSUE on the same block.
  - Else set `fail`, set `fail_block = step_col_block`, and go to FINISH. A pending abort does not change this outcome.
- **Abort:** `abort` sampled in CHECK/ISSUE/WAIT sets a sticky abort flag.
  - In CHECK or ISSUE with the flag set, go straight to FINISH with `aborted=1` and no further `step_start`.
  - A step in flight is always drained; the block never leaves WAIT without `step_done`.
- **FINISH:** `done=1` for one cycle, then go to IDLE. `busy` is low from the next cycle.
- `start` while busy is ignored, with no effect on any latched value. `step_done` in IDLE/CHECK/ISSUE/FINISH is ignored.

## Timing
- Reset (`rst=0`, async): state IDLE. Every output is 0, including `step_col_block`, `step_first_pass_rows` and the counters. The abort flag and `retry_cnt` are cleared. Reset mid-run abandons the run without a `done`.
- Start latency:
  - `start` sampled at cycle t.
  - CHECK at t+1, with `busy=1`.
  - `step_start` at t+2.
- Inter-step latency: `step_done` at cycle u gives the next `step_start` at u+1 (ISSUE at u+1). The same holds for a retry.
- Completion latency: final `step_done` at cycle u gives `done` at u+1.
- Range error: `done` with `fail=range_err=1` at t+2.
- `step_done`, `step_fail` and `abort` in the same cycle: the step result is evaluated first. Abort only prevents a further issue, so on the last block the run reports success with `aborted=0`.
- `steps_ok` never exceeds `NB`. The `step_first_pass_rows` arithmetic is unsigned and computed at width FW; no overflow for legal blocks.

## Test plan
- **Full range:** N=4, L=8, K=16, `start_block=0`, `end_block=3`, engine `step_done` 5 cycles after each `step_start`.
  - 4 `step_start` pulses with `step_col_block` 0,1,2,3.
  - `step_functionA` high only around step 0.
  - `done` 1 cycle after the 4th `step_done`, with `fail=0` and `steps_ok=4`.
- **Partial range:** `start_block=2`, `end_block=3` gives `step_first_pass_rows=16`, blocks 2,3 issued, `steps_ok=2`.
- **Retry success:** MAX_RETRY=1, fail on the first attempt at block 1. Block 1 is re-issued the next cycle, the run completes, `fail=0`, `steps_ok=4`.
- **Retry exhaustion:** MAX_RETRY=1, fail twice at block 1. Result `done` with `fail=1`, `fail_block=1`, `steps_ok=1`, and no block-2 issue.
- **Abort during WAIT of block 1:**
  - No `step_start` after block 1's `step_done`.
  - `done` the next cycle with `aborted=1`, `steps_ok=2`.
  - `start` asserted while busy has no effect.
- **Range error and reset:**
  - `start_block=3`, `end_block=1` gives `done` at t+2 with `range_err=1`, `fail=1`, and zero `step_start` pulses.
  - Then assert `rst=0` mid-run in WAIT: all outputs are 0 immediately and no `done` is produced.
